// File: rtl/arrtm_errmon_pkg.sv
// Shared types and widths for the truncated-multiplier error monitor.
// Optional feature macro: U_ARRTM8_ERRMON_WCE_EN (worst-case operand capture).
package arrtm_errmon_pkg;

    localparam int OP_W   = 8;
    localparam int PROD_W = 16;
    localparam int SUM_W  = 32;
    localparam int CNT_W  = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/u_arrtm8_errmon_abs_err16.sv
// Exact 8x8 unsigned product and its absolute distance from the approximate product.
module abs_err16
    import arrtm_errmon_pkg::*;
(
    input  logic [OP_W-1:0]   i_a,
    input  logic [OP_W-1:0]   i_b,
    input  logic [PROD_W-1:0] i_p_approx,
    output logic [PROD_W-1:0] o_abs_err
);

    logic [PROD_W-1:0] w_exact;

    assign w_exact   = PROD_W'(i_a) * PROD_W'(i_b);
    assign o_abs_err = (w_exact >= i_p_approx) ? (w_exact - i_p_approx)
                                               : (i_p_approx - w_exact);

endmodule

// File: rtl/u_arrtm8_errmon.sv
// Error-statistics monitor: accepts samples, runs a 2-stage error pipeline, accumulates stats.
// Optional feature macro: U_ARRTM8_ERRMON_WCE_EN captures the operands of the worst-case error.
module u_arrtm8_errmon
    import arrtm_errmon_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [CNT_W-1:0]   num_samples,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [OP_W-1:0]    a,
    input  logic [OP_W-1:0]    b,
    input  logic [PROD_W-1:0]  p_approx,
    output logic               busy,
    output logic               done,
    output logic [SUM_W-1:0]   sum_abs_err,
    output logic [PROD_W-1:0]  max_abs_err,
    output logic [CNT_W-1:0]   err_cnt,
    output logic [CNT_W-1:0]   sample_cnt,
    output logic [OP_W-1:0]    wce_a,
    output logic [OP_W-1:0]    wce_b
);

    state_t              r_state, w_state_nxt;
    logic [CNT_W-1:0]    r_num, r_acc_cnt;
    logic                r_s0_vld, r_s1_vld;
    logic [OP_W-1:0]     r_s0_a, r_s0_b;
    logic [PROD_W-1:0]   r_s0_p, r_s1_err, w_abs_err;
    logic [SUM_W-1:0]    r_sum;
    logic [PROD_W-1:0]   r_max;
    logic [CNT_W-1:0]    r_err_cnt, r_sample_cnt;
    logic                w_start, w_hs, w_last, w_new_max;

    assign in_ready  = (r_state == ST_RUN);
    assign busy      = (r_state == ST_RUN) || (r_state == ST_DRAIN);
    assign done      = (r_state == ST_DONE);
    assign w_start   = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_hs      = in_valid && in_ready;
    assign w_last    = (r_acc_cnt + CNT_W'(1)) == r_num;
    assign w_new_max = r_s1_err > r_max;

    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE, ST_DONE: if (start) w_state_nxt = (num_samples == '0) ? ST_DONE : ST_RUN;
            ST_RUN:           if (w_hs && w_last) w_state_nxt = ST_DRAIN;
            // Last sample's stats land when only stage 1 still holds data.
            ST_DRAIN:         if (r_s1_vld && !r_s0_vld) w_state_nxt = ST_DONE;
            default:          w_state_nxt = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_num     <= '0;
            r_acc_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_start) begin
                r_num     <= num_samples;
                r_acc_cnt <= '0;
            end else if (w_hs) begin
                r_acc_cnt <= r_acc_cnt + CNT_W'(1);
            end
        end
    end

    abs_err16 u_abs_err (
        .i_a        (r_s0_a),
        .i_b        (r_s0_b),
        .i_p_approx (r_s0_p),
        .o_abs_err  (w_abs_err)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s0_vld <= 1'b0;
            r_s0_a   <= '0;
            r_s0_b   <= '0;
            r_s0_p   <= '0;
            r_s1_vld <= 1'b0;
            r_s1_err <= '0;
        end else begin
            r_s0_vld <= w_hs;
            if (w_hs) begin
                r_s0_a <= a;
                r_s0_b <= b;
                r_s0_p <= p_approx;
            end
            r_s1_vld <= r_s0_vld;
            if (r_s0_vld) r_s1_err <= w_abs_err;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sum        <= '0;
            r_max        <= '0;
            r_err_cnt    <= '0;
            r_sample_cnt <= '0;
        end else if (w_start) begin
            r_sum        <= '0;
            r_max        <= '0;
            r_err_cnt    <= '0;
            r_sample_cnt <= '0;
        end else if (r_s1_vld) begin
            r_sum        <= r_sum + SUM_W'(r_s1_err);
            r_sample_cnt <= r_sample_cnt + CNT_W'(1);
            if (r_s1_err != '0) r_err_cnt <= r_err_cnt + CNT_W'(1);
            if (w_new_max)      r_max     <= r_s1_err;
        end
    end

`ifdef U_ARRTM8_ERRMON_WCE_EN
    logic [OP_W-1:0] r_s1_a, r_s1_b, r_wce_a, r_wce_b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_a  <= '0;
            r_s1_b  <= '0;
            r_wce_a <= '0;
            r_wce_b <= '0;
        end else begin
            if (r_s0_vld) begin
                r_s1_a <= r_s0_a;
                r_s1_b <= r_s0_b;
            end
            if (w_start) begin
                r_wce_a <= '0;
                r_wce_b <= '0;
            end else if (r_s1_vld && w_new_max) begin
                r_wce_a <= r_s1_a;
                r_wce_b <= r_s1_b;
            end
        end
    end

    assign wce_a = r_wce_a;
    assign wce_b = r_wce_b;
`else
    assign wce_a = '0;
    assign wce_b = '0;
`endif

    assign sum_abs_err = r_sum;
    assign max_abs_err = r_max;
    assign err_cnt     = r_err_cnt;
    assign sample_cnt  = r_sample_cnt;

endmodule

// File: tb/tb_u_arrtm8_errmon.sv
// Directed self-checking bench for u_arrtm8_errmon; expected values are hand-computed.
module tb_u_arrtm8_errmon;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] num_samples;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  a, b;
    logic [15:0] p_approx;
    logic        busy, done;
    logic [31:0] sum_abs_err;
    logic [15:0] max_abs_err, err_cnt, sample_cnt;
    logic [7:0]  wce_a, wce_b;

    int n_pass  = 0;
    int n_total = 0;

    u_arrtm8_errmon dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .num_samples (num_samples),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .a           (a),
        .b           (b),
        .p_approx    (p_approx),
        .busy        (busy),
        .done        (done),
        .sum_abs_err (sum_abs_err),
        .max_abs_err (max_abs_err),
        .err_cnt     (err_cnt),
        .sample_cnt  (sample_cnt),
        .wce_a       (wce_a),
        .wce_b       (wce_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
    endtask

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic begin_run(input logic [15:0] n);
        start       = 1'b1;
        num_samples = n;
        tick();
        start       = 1'b0;
    endtask

    task automatic offer(input logic v, input logic [7:0] va, input logic [7:0] vb,
                         input logic [15:0] vp);
        in_valid = v;
        a        = va;
        b        = vb;
        p_approx = vp;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        for (int i = 0; i < 20 && !done; i++) tick();
        check(tag, {31'd0, done}, 32'd1);
    endtask

    task automatic check_stats(input string tag, input logic [31:0] s, input logic [15:0] m,
                               input logic [15:0] e, input logic [15:0] c);
        check({tag, ".sum"},        sum_abs_err, s);
        check({tag, ".max"},        {16'd0, max_abs_err}, {16'd0, m});
        check({tag, ".err_cnt"},    {16'd0, err_cnt}, {16'd0, e});
        check({tag, ".sample_cnt"}, {16'd0, sample_cnt}, {16'd0, c});
    endtask

    task automatic check_all_zero(input string tag);
        check_stats(tag, 32'd0, 16'd0, 16'd0, 16'd0);
        check({tag, ".flags"}, {29'd0, in_ready, busy, done}, 32'd0);
        check({tag, ".wce"},   {16'd0, wce_a, wce_b}, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; num_samples = '0;
        in_valid = 1'b0; a = '0; b = '0; p_approx = '0;
        tick();
        check_all_zero("reset");
        rst_n = 1'b1;
        tick();
        check("idle_ready", {31'd0, in_ready}, 32'd0);

        // Single sample 7*7 vs 0: done two edges after acceptance.
        begin_run(16'd1);
        check("run1.flags", {30'd0, in_ready, busy}, 32'd3);
        offer(1'b1, 8'd7, 8'd7, 16'd0);
        check("run1.e0_done", {31'd0, done}, 32'd0);
        tick();
        check("run1.e1_done", {31'd0, done}, 32'd0);
        tick();
        check("run1.e2_done", {31'd0, done}, 32'd1);
        check_stats("run1", 32'd49, 16'd49, 16'd1, 16'd1);
        check("run1.busy", {31'd0, busy}, 32'd0);

        // Four exact samples back to back.
        begin_run(16'd4);
        in_valid = 1'b1; a = 8'd255; b = 8'd255; p_approx = 16'd65025;
        tick(); tick(); tick(); tick();
        in_valid = 1'b0;
        check("run4.ready_after_last", {31'd0, in_ready}, 32'd0);
        check("run4.busy_drain", {31'd0, busy}, 32'd1);
        wait_done("run4.done");
        check_stats("run4", 32'd0, 16'd0, 16'd0, 16'd4);

        // Gapped handshakes; 4th offer and a start pulse land in DRAIN and are ignored.
        begin_run(16'd3);
        offer(1'b1, 8'd1, 8'd1, 16'd0);
        offer(1'b0, 8'd0, 8'd0, 16'd0);
        offer(1'b1, 8'd2, 8'd2, 16'd0);
        offer(1'b0, 8'd0, 8'd0, 16'd0);
        offer(1'b1, 8'd3, 8'd3, 16'd0);
        check("gap.ready_drain", {31'd0, in_ready}, 32'd0);
        start = 1'b1; num_samples = 16'd7;
        offer(1'b1, 8'd9, 8'd9, 16'd0);
        start = 1'b0;
        wait_done("gap.done");
        check_stats("gap", 32'd14, 16'd9, 16'd3, 16'd3);
        tick(); tick(); tick();
        check_stats("gap_hold", 32'd14, 16'd9, 16'd3, 16'd3);

        // Tied maxima keep the first occurrence.
        begin_run(16'd3);
        offer(1'b1, 8'd2, 8'd3, 16'd0);
        offer(1'b1, 8'd3, 8'd2, 16'd0);
        offer(1'b1, 8'd1, 8'd1, 16'd0);
        wait_done("tie.done");
        check_stats("tie", 32'd13, 16'd6, 16'd3, 16'd3);
`ifdef U_ARRTM8_ERRMON_WCE_EN
        check("tie.wce", {16'd0, wce_a, wce_b}, {16'd0, 8'd2, 8'd3});
`else
        check("tie.wce", {16'd0, wce_a, wce_b}, 32'd0);
`endif

        // Zero-length run goes straight to DONE with cleared stats.
        begin_run(16'd0);
        check("zero.done", {31'd0, done}, 32'd1);
        check("zero.ready", {31'd0, in_ready}, 32'd0);
        check_stats("zero", 32'd0, 16'd0, 16'd0, 16'd0);
        check("zero.wce", {16'd0, wce_a, wce_b}, 32'd0);
        tick();
        check("zero.ready_hold", {30'd0, in_ready, done}, 32'd1);

        // Reset mid-run with samples in flight and stats already nonzero.
        begin_run(16'd5);
        offer(1'b1, 8'd4, 8'd4, 16'd0);
        offer(1'b1, 8'd5, 8'd5, 16'd0);
        offer(1'b1, 8'd6, 8'd6, 16'd0);
        check("midrun.sum_before", sum_abs_err, 32'd16);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("midrun_reset");
        tick();
        rst_n = 1'b1;
        tick(); tick();
        check("post_reset.flags", {29'd0, in_ready, busy, done}, 32'd0);
        check_stats("post_reset", 32'd0, 16'd0, 16'd0, 16'd0);

        // Fresh run after reset sees only its own sample: |25-20| = 5.
        begin_run(16'd1);
        offer(1'b1, 8'd5, 8'd5, 16'd20);
        wait_done("after_reset.done");
        check_stats("after_reset", 32'd5, 16'd5, 16'd1, 16'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/u_arrtm8_errmon.md
U_ARRTM8_ERRMON -- requirements
Module: u_arrtm8_errmon

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset. Ports: clk  in  1  rising-edge clock; rst_n  in  1  asynchronous active-low reset.
REQ-002 SHALL have: start  in  1  clear statistics and begin a run (honoured in IDLE/DONE only).
REQ-003 SHALL have: num_samples  in  16  number of samples to accept in a run; sampled on start.
REQ-004 SHALL have: in_valid  in  1; in_ready  out  1  sample handshake, transfer when both are 1.
REQ-005 SHALL have: a  in  8; b  in  8  operands fed to the 8x8 truncated multiplier.
REQ-006 SHALL have: p_approx  in  16  that multiplier's product for (a,b).
REQ-007 SHALL have: busy  out  1  (RUN or DRAIN); done  out  1  (level, DONE state).
REQ-008 SHALL have: sum_abs_err  out  32; max_abs_err  out  16; err_cnt  out  16  (samples with nonzero error); sample_cnt  out  16.
REQ-009 SHALL have: wce_a  out  8; wce_b  out  8  operands of worst-case error (see Configuration).

Function
REQ-010 SHALL implement FSM IDLE, RUN, DRAIN, DONE.
REQ-011 IDLE/DONE + start: clear all statistics, latch num_samples, go to RUN; if the latched num_samples is 0, go to DONE instead, with statistics zero.
REQ-012 start SHALL be ignored in RUN and DRAIN.
REQ-013 in_ready SHALL be 1 only in RUN; it is combinational from state.
REQ-014 RUN: on the handshake that makes the accepted count equal num_samples, go to DRAIN; in_valid SHALL be ignored outside RUN.
REQ-015 Pipeline: acceptance at edge E0 registers a, b, p_approx. At E1 the stage registers exact = a*b (16 bit, unsigned) and abs_err = |exact - p_approx| (16 bit). At E2 the stage updates the statistics.
REQ-016 DRAIN SHALL exit to DONE on the edge that applies the last sample's statistics (E2 of the last sample). done and final statistics SHALL become visible together.
REQ-017 Per sample: sample_cnt +1; sum_abs_err += abs_err; err_cnt +1 if abs_err != 0; max_abs_err = abs_err if strictly greater, so ties keep the first occurrence.
REQ-018 sum_abs_err SHALL NOT saturate or wrap; 65535*65535 < 2^32 guarantees this by width.
REQ-019 Statistics SHALL hold their values in DONE until the next start.
REQ-020 Back-to-back handshakes SHALL be sustained at one sample per cycle; gaps in in_valid SHALL not alter results.

Reset
REQ-021 rst_n low SHALL immediately force: state IDLE, all statistics 0, wce_a/wce_b 0, in_ready 0, busy 0, done 0, pipeline valids 0.
REQ-022 A reset in mid-run SHALL discard in-flight samples. After rst_n is released, the block SHALL wait in IDLE for start.

Configuration
REQ-023 Macro U_ARRTM8_ERRMON_WCE_EN: when defined, wce_a/wce_b SHALL capture the a/b of the sample that updates max_abs_err. Capture SHALL happen in the same edge as that update and SHALL clear on start.
REQ-024 Without U_ARRTM8_ERRMON_WCE_EN: wce_a/wce_b SHALL be constant 0, with no capture registers present; the ports SHALL remain.

Structure
REQ-025 Package arrtm_errmon_pkg SHALL hold: the state enum, OP_W=8, PROD_W=16, SUM_W=32, CNT_W=16.
REQ-026 Sub-module abs_err16 SHALL hold the combinational exact product and absolute difference used by stage E1. The FSM and accumulators SHALL stay in u_arrtm8_errmon.

Verification
REQ-027 Reset: assert rst_n=0 mid-run -> all outputs 0 in the same cycle; after release state is IDLE, in_ready=0.
REQ-028 num_samples=1, sample (a=7,b=7,p_approx=0) -> after DONE: sum=49, max=49, err_cnt=1, sample_cnt=1; done rises 2 edges after acceptance.
REQ-029 num_samples=4, four samples (255,255,65025) -> sum=0, max=0, err_cnt=0, sample_cnt=4; in_ready=0 from the edge after the 4th handshake.
REQ-030 num_samples=3, in_valid pattern 1,0,1,0,1,1 with p_approx=0 and a=b=1,2,3 then a=b=9 -> sum=14, max=9, sample_cnt=3; the 4th offer is not accepted.
REQ-031 Ties, with the macro defined: (2,3,0), (3,2,0), (1,1,0) -> max=6, wce_a=2, wce_b=3, err_cnt=3, sum=13. Same stimulus without the macro -> wce_a=wce_b=0.
REQ-032 start with num_samples=0 -> done=1 on the next edge, all statistics 0, in_ready never 1. A start pulse during DRAIN -> ignored, and results are unchanged.
